// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle MIPS control FSM driving datapath strobes and selects
module mc_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       i_rdy,
    input  logic       d_rdy,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       ir_we,
    output logic [1:0] ext_op,
    output logic [2:0] alu_ctrl,
    output logic       alu_src_b,
    output logic       mem_re,
    output logic       mem_we,
    output logic       reg_we,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXE    = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic is_rtype, is_addu, is_subu, is_addiu, is_ori, is_lui;
    logic is_lw, is_sw, is_beq, is_j, legal;
    logic [1:0] dec_ext;
    logic [2:0] dec_alu;
    logic       dec_src_b;

    assign is_rtype = (opcode == 6'b000000);
    assign is_addu  = is_rtype && (funct == 6'b100001);
    assign is_subu  = is_rtype && (funct == 6'b100011);
    assign is_addiu = (opcode == 6'b001001);
    assign is_ori   = (opcode == 6'b001101);
    assign is_lui   = (opcode == 6'b001111);
    assign is_lw    = (opcode == 6'b100011);
    assign is_sw    = (opcode == 6'b101011);
    assign is_beq   = (opcode == 6'b000100);
    assign is_j     = (opcode == 6'b000010);
    assign legal    = is_addu | is_subu | is_addiu | is_ori | is_lui |
                      is_lw | is_sw | is_beq | is_j;

    always_comb begin
        dec_ext   = 2'b00;
        dec_alu   = 3'b000;
        dec_src_b = 1'b0;
        if (is_addiu || is_lw || is_sw || is_beq) dec_ext = 2'b01;
        else if (is_lui)                          dec_ext = 2'b10;
        if (is_subu || is_beq)  dec_alu = 3'b001;
        else if (is_ori)        dec_alu = 3'b010;
        else if (is_lui)        dec_alu = 3'b011;
        dec_src_b = is_addiu | is_ori | is_lui | is_lw | is_sw;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        pc_we      = 1'b0;
        pc_src     = 2'b00;
        ir_we      = 1'b0;
        ext_op     = 2'b00;
        alu_ctrl   = 3'b000;
        alu_src_b  = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;

        // Datapath selects track the IR for the whole instruction after fetch
        if (state inside {DECODE, EXE, MEM, WB}) begin
            ext_op     = dec_ext;
            alu_ctrl   = dec_alu;
            alu_src_b  = dec_src_b;
            reg_dst    = is_rtype;
            mem_to_reg = is_lw;
        end

        case (state)
            FETCH: begin
                if (i_rdy) begin
                    ir_we     = 1'b1;
                    pc_we     = 1'b1;
                    state_nxt = DECODE;
                end
            end
            DECODE: begin
                if (!legal) begin
                    illegal   = 1'b1;
                    state_nxt = FETCH;
                end else begin
                    state_nxt = EXE;
                end
            end
            EXE: begin
                if (is_beq) begin
                    pc_we     = zero;
                    pc_src    = 2'b01;
                    state_nxt = FETCH;
                end else if (is_j) begin
                    pc_we     = 1'b1;
                    pc_src    = 2'b10;
                    state_nxt = FETCH;
                end else if (is_lw || is_sw) begin
                    state_nxt = MEM;
                end else begin
                    state_nxt = WB;
                end
            end
            MEM: begin
                mem_re = is_lw;
                mem_we = is_sw;
                if (d_rdy) state_nxt = is_lw ? WB : FETCH;
            end
            WB: begin
                reg_we    = 1'b1;
                state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
        endcase

        // Reset masks everything at once so an in-flight memory access is dropped
        if (rst) begin
            pc_we      = 1'b0;
            pc_src     = 2'b00;
            ir_we      = 1'b0;
            ext_op     = 2'b00;
            alu_ctrl   = 3'b000;
            alu_src_b  = 1'b0;
            mem_re     = 1'b0;
            mem_we     = 1'b0;
            reg_we     = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            illegal    = 1'b0;
        end
    end

endmodule
